// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control codes plus the multiply/divide FSM encoding and iteration count.
package muldiv_unit_pkg;

  localparam logic [4:0] ALUCTRL_ADD    = 5'd0;
  localparam logic [4:0] ALUCTRL_MUL    = 5'd16;
  localparam logic [4:0] ALUCTRL_MULH   = 5'd17;
  localparam logic [4:0] ALUCTRL_MULHSU = 5'd18;
  localparam logic [4:0] ALUCTRL_MULHU  = 5'd19;
  localparam logic [4:0] ALUCTRL_DIV    = 5'd20;
  localparam logic [4:0] ALUCTRL_DIVU   = 5'd21;
  localparam logic [4:0] ALUCTRL_REM    = 5'd22;
  localparam logic [4:0] ALUCTRL_REMU   = 5'd23;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } muldiv_state_t;

  function automatic logic is_muldiv(input logic [4:0] code);
    return (code >= ALUCTRL_MUL) && (code <= ALUCTRL_REMU);
  endfunction

  function automatic logic is_mul_code(input logic [4:0] code);
    return (code >= ALUCTRL_MUL) && (code <= ALUCTRL_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one restoring divide iteration on unsigned magnitudes.
// Purely combinational; the caller owns the remainder/quotient registers.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0]   shifted;
  logic         ge;
  logic [W-1:0] diff;

  assign shifted = {rem_in, quo_in[W-1]};
  assign ge      = shifted >= {1'b0, divisor};
  // rem_in < divisor always holds, so a successful subtract fits in W bits.
  assign diff    = shifted[W-1:0] - divisor;
  assign rem_out = ge ? diff : shifted[W-1:0];
  assign quo_out = {quo_in[W-2:0], ge};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 cycles in CALC, one-cycle out_valid pulse in DONE.
// Div-by-zero and signed overflow finish in one cycle; MULDIV_FAST_MUL_EN makes multiply single-cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [4:0]      ALUCtrl,
  input  logic [BITS-1:0] op_a,
  input  logic [BITS-1:0] op_b,
  input  logic            flush,
  output logic            in_ready,
  output logic            busy,
  output logic            out_valid,
  output logic [BITS-1:0] result
);

  muldiv_state_t   state_q, state_d;
  logic [4:0]      op_q;
  logic [5:0]      cnt_q;
  logic [BITS-1:0] hi_q, lo_q, opnd_q, result_q;
  logic            neg_q, neg_rem_q;

  logic            in_mul, a_signed, b_signed, a_neg, b_neg, rem_code;
  logic            div_zero, div_ovf, fast_mul, early, accept, last;
  logic [BITS-1:0] abs_a, abs_b, early_res, fast_res;

  assign in_mul   = is_mul_code(ALUCtrl);
  assign a_signed = ALUCtrl inside {ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_DIV, ALUCTRL_REM};
  assign b_signed = ALUCtrl inside {ALUCTRL_MULH, ALUCTRL_DIV, ALUCTRL_REM};
  assign a_neg    = a_signed & op_a[BITS-1];
  assign b_neg    = b_signed & op_b[BITS-1];
  assign abs_a    = a_neg ? -op_a : op_a;
  assign abs_b    = b_neg ? -op_b : op_b;
  assign rem_code = (ALUCtrl == ALUCTRL_REM) || (ALUCtrl == ALUCTRL_REMU);
  assign div_zero = !in_mul && (op_b == '0);
  assign div_ovf  = ((ALUCtrl == ALUCTRL_DIV) || (ALUCtrl == ALUCTRL_REM))
                    && (op_a == {1'b1, {(BITS-1){1'b0}}}) && (&op_b);

`ifdef MULDIV_FAST_MUL_EN
  // a_neg/b_neg double as the 33rd bit: sign for signed operands, zero otherwise.
  logic signed [BITS:0]     fast_a, fast_b;
  logic signed [2*BITS-1:0] fast_prod;
  assign fast_a    = {a_neg, op_a};
  assign fast_b    = {b_neg, op_b};
  assign fast_prod = (2*BITS)'(fast_a) * (2*BITS)'(fast_b);
  assign fast_mul  = in_mul;
  assign fast_res  = (ALUCtrl == ALUCTRL_MUL) ? fast_prod[BITS-1:0] : fast_prod[2*BITS-1:BITS];
`else
  assign fast_mul  = 1'b0;
  assign fast_res  = '0;
`endif

  assign early  = div_zero | div_ovf | fast_mul;
  assign accept = in_valid && (state_q == ST_IDLE) && is_muldiv(ALUCtrl) && !flush;
  assign last   = cnt_q == 6'(MULDIV_ITERS - 1);

  always_comb begin
    early_res = '0;
    if (fast_mul)      early_res = fast_res;
    else if (div_zero) early_res = rem_code ? op_a : '1;
    else if (div_ovf)  early_res = rem_code ? '0 : op_a;
  end

  // Shift-add multiply: {hi,lo} is the product, lo initially holds the multiplier.
  logic [BITS:0]     mul_sum;
  logic [BITS-1:0]   mul_hi_d, mul_lo_d, div_rem_d, div_quo_d, step_hi, step_lo;
  logic [2*BITS-1:0] prod, sprod;
  logic [BITS-1:0]   quo_s, rem_s, final_res;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_hi_d = mul_sum[BITS:1];
  assign mul_lo_d = {mul_sum[0], lo_q[BITS-1:1]};

  div_step #(.W(BITS)) u_div_step (
    .rem_in  (hi_q),
    .quo_in  (lo_q),
    .divisor (opnd_q),
    .rem_out (div_rem_d),
    .quo_out (div_quo_d)
  );

  assign step_hi = is_mul_code(op_q) ? mul_hi_d : div_rem_d;
  assign step_lo = is_mul_code(op_q) ? mul_lo_d : div_quo_d;
  assign prod    = {mul_hi_d, mul_lo_d};
  assign sprod   = neg_q ? -prod : prod;
  assign quo_s   = neg_q ? -div_quo_d : div_quo_d;
  assign rem_s   = neg_rem_q ? -div_rem_d : div_rem_d;

  always_comb begin
    final_res = rem_s;
    case (op_q)
      ALUCTRL_MUL:                                    final_res = sprod[BITS-1:0];
      ALUCTRL_MULH, ALUCTRL_MULHSU, ALUCTRL_MULHU:    final_res = sprod[2*BITS-1:BITS];
      ALUCTRL_DIV, ALUCTRL_DIVU:                      final_res = quo_s;
      default:                                        final_res = rem_s;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = early ? ST_DONE : ST_CALC;
      ST_CALC: if (last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else if (accept) begin
      op_q      <= ALUCtrl;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= in_mul ? abs_b : abs_a;
      opnd_q    <= in_mul ? abs_a : abs_b;
      neg_q     <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      if (early) result_q <= early_res;
    end else if ((state_q == ST_CALC) && !flush) begin
      cnt_q <= cnt_q + 6'd1;
      hi_q  <= step_hi;
      lo_q  <= step_lo;
      if (last) result_q <= final_res;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vectors for muldiv_unit: latency, results, divide corner cases, flush and reset.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  alu_ctrl = ALUCTRL_ADD;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        in_ready, busy, out_valid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit #(.BITS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .ALUCtrl   (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .in_ready  (in_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the negedge of cycle N+1 after an accept at cycle N.
  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " in_ready in done"}, 32'(in_ready), 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [4:0] code, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = code; op_a = a; op_b = b;
    @(negedge clk);
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    wait_done(tag, exp_lat, exp_res);
  endtask

  initial begin
    logic [4:0] flush_code;
    int         stray;

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);

    // Accept on the very first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; alu_ctrl = ALUCTRL_MULHU;
    op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    wait_done("mulhu max", MUL_LAT, 32'hFFFF_FFFE);

    do_op("mul 3x4",        ALUCTRL_MUL,    32'd3,        32'd4,        MUL_LAT, 32'd12);
    do_op("mul -3x5",       ALUCTRL_MUL,    32'hFFFF_FFFD, 32'd5,       MUL_LAT, 32'hFFFF_FFF1);
    do_op("mulh -3x5",      ALUCTRL_MULH,   32'hFFFF_FFFD, 32'd5,       MUL_LAT, 32'hFFFF_FFFF);
    do_op("mulh min2",      ALUCTRL_MULH,   32'h8000_0000, 32'h8000_0000, MUL_LAT, 32'h4000_0000);
    do_op("mulhsu min max", ALUCTRL_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, MUL_LAT, 32'h8000_0000);
    do_op("mulhsu -1x2",    ALUCTRL_MULHSU, 32'hFFFF_FFFF, 32'd2,       MUL_LAT, 32'hFFFF_FFFF);
    do_op("div -7/2",       ALUCTRL_DIV,    32'hFFFF_FFF9, 32'd2,       33, 32'hFFFF_FFFD);
    do_op("rem -7/2",       ALUCTRL_REM,    32'hFFFF_FFF9, 32'd2,       33, 32'hFFFF_FFFF);
    do_op("div 7/-2",       ALUCTRL_DIV,    32'd7,        32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    do_op("rem 7/-2",       ALUCTRL_REM,    32'd7,        32'hFFFF_FFFE, 33, 32'd1);
    do_op("divu 100/7",     ALUCTRL_DIVU,   32'd100,      32'd7,        33, 32'd14);
    do_op("remu 100/7",     ALUCTRL_REMU,   32'd100,      32'd7,        33, 32'd2);
    do_op("divu min/max",   ALUCTRL_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0);
    do_op("divu 5/0",       ALUCTRL_DIVU,   32'd5,        32'd0,        1, 32'hFFFF_FFFF);
    do_op("remu 5/0",       ALUCTRL_REMU,   32'd5,        32'd0,        1, 32'd5);
    do_op("rem -7/0",       ALUCTRL_REM,    32'hFFFF_FFF9, 32'd0,       1, 32'hFFFF_FFF9);
    do_op("div ovf",        ALUCTRL_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    do_op("rem ovf",        ALUCTRL_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

    // flush together with in_valid in IDLE must not accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; alu_ctrl = ALUCTRL_MUL; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush+valid busy", 32'(busy), 32'd0);
    check("flush+valid in_ready", 32'(in_ready), 32'd1);

    // Flush at N+10 abandons the op; a fresh op at N+11 runs its full latency.
    flush_code = (MUL_LAT == 1) ? ALUCTRL_DIVU : ALUCTRL_MUL;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = flush_code; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("busy before flush", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1; alu_ctrl = ALUCTRL_MUL; op_a = 32'd3; op_b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    wait_done("mul after flush", MUL_LAT, 32'd12);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush in done keeps result", result, 32'd12);
    check("flush in done busy", 32'(busy), 32'd0);

    // Reset mid-divide, then hold an ADD code: nothing may come out.
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = ALUCTRL_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset result", result, 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; alu_ctrl = ALUCTRL_ADD;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid || busy) stray++;
    end
    in_valid = 1'b0;
    check("no activity after reset/add", 32'(stray), 32'd0);

    do_op("divu after reset", ALUCTRL_DIVU, 32'd100, 32'd7, 33, 32'd14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 BITS, 32, operand/result width; only 32 is supported.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 in_valid  in  1  decode stage presents an operation this cycle.
REQ-005 ALUCtrl  in  5  operation code from the decode stage, encoded with the shared ALUCTRL_* constants.
REQ-006 op_a  in  BITS  rs1 value (dividend / multiplicand).
REQ-007 op_b  in  BITS  rs2 value (divisor / multiplier).
REQ-008 flush  in  1  synchronous abort of any in-flight operation.
REQ-009 in_ready  out  1  high only in IDLE.
REQ-010 busy  out  1  high when state is not IDLE; pipeline stall request.
REQ-011 out_valid  out  1  one-cycle pulse; result is valid.
REQ-012 result  out  BITS  registered result; holds its value until the next out_valid.

Function
REQ-013 The unit SHALL accept an operation when in_valid, in_ready and ALUCtrl is one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; other codes SHALL be ignored with no state change.
REQ-014 The FSM SHALL have states IDLE, CALC and DONE.
REQ-015 Transitions: IDLE->CALC on accept; CALC->DONE after 32 iterations; DONE->IDLE unconditionally after one cycle.
REQ-016 On accept, the unit SHALL latch the operation, operand absolute values and result-sign flags, and SHALL clear the iteration counter (6 bits) to 0.
REQ-017 CALC SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per cycle, with counter 0..31.
REQ-018 out_valid SHALL be high exactly in DONE, so accept at cycle N gives out_valid at N+33.
REQ-019 The earliest next accept after an out_valid at cycle N SHALL be cycle N+1.
REQ-020 Result selection:
  - MUL: low 32 bits of the 64-bit product.
  - MULH: high 32 bits, signed x signed.
  - MULHSU: high 32 bits, signed x unsigned.
  - MULHU: high 32 bits, unsigned x unsigned.
  - DIV/REM: signed, quotient truncated toward zero, remainder takes the sign of the dividend.
  - DIVU/REMU: unsigned.
REQ-021 Divide by zero SHALL be detected at accept and go IDLE->DONE directly (out_valid at N+1), with result:
  - DIV/DIVU: all ones.
  - REM/REMU: op_a.
REQ-022 Signed overflow (DIV/REM with op_a=32'h8000_0000, op_b=32'hFFFF_FFFF) SHALL also go directly to DONE at N+1, with DIV=32'h8000_0000 and REM=0.
REQ-023 flush SHALL have priority over every other input and return the FSM to IDLE next cycle with no out_valid; flush in DONE SHALL suppress nothing already pulsed but SHALL leave result unchanged.
REQ-024 flush and in_valid in the same IDLE cycle SHALL NOT accept.
REQ-025 Operand changes during CALC SHALL have no effect.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state=IDLE, counter=0, out_valid=0, result=0 and all internal datapath registers=0, so busy=0 and in_ready=1.
REQ-027 Reset asserted mid-CALC SHALL abandon the operation with no out_valid after release.
REQ-028 The first accept SHALL be possible in the first clock edge after rst_n deasserts.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN SHALL select the multiply implementation.
  - Defined: the four multiply codes SHALL compute with a single-cycle 33x33 signed multiplier and go IDLE->DONE directly (out_valid at N+1); divide is unchanged.
  - Undefined: multiply SHALL use the iterative path of REQ-017 (out_valid at N+33).

Structure
REQ-030 The ALUCTRL_* codes SHALL come from the shared ALU control definitions; the FSM state encoding and the iteration count constant (32) SHALL be added to that shared package.
REQ-031 The restoring divider step logic SHALL be a sub-module, div_step, instantiated once; the multiply step and FSM SHALL stay in muldiv_unit.

Verification
REQ-032 MULHU, 32'hFFFF_FFFF x 32'hFFFF_FFFF -> out_valid at N+33 (N+1 with macro), result 32'hFFFF_FFFE.
REQ-033 DIV, -7 / 2 -> result 32'hFFFF_FFFD; REM, -7 / 2 -> result 32'hFFFF_FFFF; both at N+33.
REQ-034 DIVU, 5 / 0 -> result 32'hFFFF_FFFF at N+1; REMU, 5 / 0 -> result 5 at N+1.
REQ-035 DIV, 32'h8000_0000 / -1 -> result 32'h8000_0000 at N+1; REM -> 0.
REQ-036 MUL 3x4 accepted, flush at N+10 -> busy=0 at N+11, no out_valid; new MUL 3x4 at N+11 -> result 12.
REQ-037 rst_n low at N+5 of a DIVU -> busy=0, out_valid=0 immediately, result=0; ADD code with in_valid -> never accepted.
